// File: rtl/intrm_pack.sv
// Word packer: gathers PACK_DEPTH input words into one wide vector behind a one-entry output register.
// Optional partial-pack flush is compiled in with INTRM_PACK_FLUSH_EN.
module intrm_pack #(
  parameter int INPUT_WIDTH  = 32,
  parameter int PACK_DEPTH   = 4,
  parameter int OUTPUT_WIDTH = PACK_DEPTH*INPUT_WIDTH,
  parameter int CNT_WIDTH    = $clog2(PACK_DEPTH+1)
) (
  input  logic                    intrm_pack_clk,
  input  logic                    intrm_pack_rst,
  input  logic                    intrm_pack_in_valid_i,
  output logic                    intrm_pack_in_ready_o,
  input  logic [INPUT_WIDTH-1:0]  intrm_pack_in_data_i,
  output logic                    intrm_pack_out_valid_o,
  input  logic                    intrm_pack_out_ready_i,
  output logic [OUTPUT_WIDTH-1:0] intrm_pack_out_data_o,
  output logic [CNT_WIDTH-1:0]    intrm_pack_out_cnt_o
`ifdef INTRM_PACK_FLUSH_EN
  ,
  input  logic                    intrm_pack_flush_i
`endif
);

  typedef enum logic [1:0] {EMPTY, FILL, FLUSH_WAIT} state_t;

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(PACK_DEPTH-1);

  state_t                                 state, state_nxt;
  logic [CNT_WIDTH-1:0]                   fill_cnt, fill_nxt;
  logic [PACK_DEPTH-2:0][INPUT_WIDTH-1:0] fill_buf;
  logic [PACK_DEPTH-1:0][INPUT_WIDTH-1:0] part_vec;
  logic [CNT_WIDTH-1:0]                   part_cnt;
  logic slot_free, accept, complete, flush_req, emit_part, load;

  assign slot_free = !intrm_pack_out_valid_o || intrm_pack_out_ready_i;
  assign intrm_pack_in_ready_o = !intrm_pack_rst && (state != FLUSH_WAIT) &&
                                 ((fill_cnt < LAST) || slot_free);
  assign accept   = intrm_pack_in_valid_i && intrm_pack_in_ready_o;
  assign complete = accept && (fill_cnt == LAST);

`ifdef INTRM_PACK_FLUSH_EN
  // A flush with nothing buffered and no word arriving has nothing to emit.
  assign flush_req = intrm_pack_flush_i && (state != FLUSH_WAIT) &&
                     ((state == FILL) || accept) && !complete;
`else
  assign flush_req = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_cnt;
    emit_part = 1'b0;
    part_vec  = '0;
    for (int i = 0; i < PACK_DEPTH-1; i++) begin
      part_vec[i] = fill_buf[i];
      if (accept && (CNT_WIDTH'(i) == fill_cnt)) part_vec[i] = intrm_pack_in_data_i;
    end
    part_cnt = fill_cnt + CNT_WIDTH'(accept);
    case (state)
      FLUSH_WAIT: begin
        if (slot_free) begin
          emit_part = 1'b1;
          state_nxt = EMPTY;
          fill_nxt  = '0;
        end
      end
      default: begin
        if (complete) begin
          state_nxt = EMPTY;
          fill_nxt  = '0;
        end else if (flush_req) begin
          if (slot_free) begin
            emit_part = 1'b1;
            state_nxt = EMPTY;
            fill_nxt  = '0;
          end else begin
            // the same-cycle word still lands in the buffer before waiting
            state_nxt = FLUSH_WAIT;
            fill_nxt  = part_cnt;
          end
        end else if (accept) begin
          state_nxt = FILL;
          fill_nxt  = fill_cnt + 1'b1;
        end
      end
    endcase
  end

  assign load = complete || emit_part;

  always_ff @(posedge intrm_pack_clk) begin
    if (intrm_pack_rst) begin
      state                  <= EMPTY;
      fill_cnt               <= '0;
      fill_buf               <= '0;
      intrm_pack_out_valid_o <= 1'b0;
      intrm_pack_out_data_o  <= '0;
      intrm_pack_out_cnt_o   <= '0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_nxt;
      if (complete) begin
        intrm_pack_out_data_o <= {intrm_pack_in_data_i, fill_buf};
        intrm_pack_out_cnt_o  <= CNT_WIDTH'(PACK_DEPTH);
      end else if (emit_part) begin
        intrm_pack_out_data_o <= part_vec;
        intrm_pack_out_cnt_o  <= part_cnt;
      end
      if (load) begin
        intrm_pack_out_valid_o <= 1'b1;
        fill_buf               <= '0;
      end else begin
        if (intrm_pack_out_valid_o && intrm_pack_out_ready_i) intrm_pack_out_valid_o <= 1'b0;
        if (accept) begin
          for (int i = 0; i < PACK_DEPTH-1; i++)
            if (CNT_WIDTH'(i) == fill_cnt) fill_buf[i] <= intrm_pack_in_data_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_intrm_pack.sv
// Bench for intrm_pack: queue-based pack model, directed scenarios plus a random run.
module tb_intrm_pack;
  localparam int W = 32, D = 4, OW = W*D, CW = $clog2(D+1);

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, flush;
  logic [W-1:0]  in_data;
  logic [OW-1:0] out_data;
  logic [CW-1:0] out_cnt;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  intrm_pack #(.INPUT_WIDTH(W), .PACK_DEPTH(D)) dut (
    .intrm_pack_clk        (clk),
    .intrm_pack_rst        (rst),
    .intrm_pack_in_valid_i (in_valid),
    .intrm_pack_in_ready_o (in_ready),
    .intrm_pack_in_data_i  (in_data),
    .intrm_pack_out_valid_o(out_valid),
    .intrm_pack_out_ready_i(out_ready),
    .intrm_pack_out_data_o (out_data),
    .intrm_pack_out_cnt_o  (out_cnt)
`ifdef INTRM_PACK_FLUSH_EN
    ,
    .intrm_pack_flush_i    (flush)
`endif
  );

  // Reference model: words of the pack in progress, the held output vector, a pending flush.
  logic [W-1:0]  part[$];
  bit            m_ov, m_fw;
  logic [OW-1:0] m_data;
  int            m_cnt;
  bit            obs_rdy, exp_rdy;

  function automatic void model_reset();
    part.delete();
    m_ov = 0; m_fw = 0; m_data = '0; m_cnt = 0;
  endfunction

  function automatic void emit();
    m_data = '0;
    foreach (part[i]) m_data[i*W +: W] = part[i];
    m_cnt = part.size();
    m_ov  = 1;
    part.delete();
  endfunction

  task automatic model_step(input bit v, input logic [W-1:0] d, input bit ordy, input bit fl,
                            output bit rdy);
    bit free, acc;
    free = !m_ov || ordy;
    rdy  = !m_fw && (part.size() < D-1 || free);
    acc  = v && rdy;
    if (m_ov && ordy) m_ov = 0;
    if (m_fw) begin
      if (free) begin emit(); m_fw = 0; end
    end else begin
      if (acc) part.push_back(d);
      if (part.size() == D) emit();
      else if (fl && part.size() > 0) begin
        if (free) emit(); else m_fw = 1;
      end
    end
  endtask

  // One clock: drive inputs, sample in_ready mid-cycle, step model, land 1 time unit past the edge.
  task automatic drive(input bit v, input logic [W-1:0] d, input bit ordy, input bit fl);
    in_valid = v; in_data = d; out_ready = ordy; flush = fl;
    @(negedge clk);
    obs_rdy = in_ready;
    model_step(v, d, ordy, fl, exp_rdy);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; in_data = '0; out_ready = 0; flush = 0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b want 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", out_data); end
    checks++; if (out_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d want 0", out_cnt); end
    model_reset();
    rst = 0;
  endtask

  task automatic test_basic();
    for (int i = 0; i < D; i++) begin
      drive(1, W'(32'h11 * (i+1)), 1, 0);
      checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL basic_rdy word %0d got %b want 1", i, obs_rdy); end
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", out_valid); end
    checks++; if (out_data !== 128'h00000044_00000033_00000022_00000011) begin errors++; $display("FAIL basic_data got %h want 00000044000000330000002200000011", out_data); end
    checks++; if (out_cnt !== CW'(4)) begin errors++; $display("FAIL basic_cnt got %0d want 4", out_cnt); end
    drive(0, '0, 1, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_hold got valid %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    int nvec = 0, nlow = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1, W'($urandom), 1, 0);
      if (!obs_rdy) nlow++;
      if (out_valid) nvec++;
      checks++; if (out_valid !== m_ov || (m_ov && (out_data !== m_data || out_cnt !== CW'(m_cnt)))) begin
        errors++; $display("FAIL stream_out cyc %0d got v=%b %h/%0d want v=%b %h/%0d", i, out_valid, out_data, out_cnt, m_ov, m_data, m_cnt); end
    end
    checks++; if (nlow != 0) begin errors++; $display("FAIL stream_rdy_low got %0d want 0", nlow); end
    checks++; if (nvec != 3) begin errors++; $display("FAIL stream_vectors got %0d want 3", nvec); end
    drive(0, '0, 1, 0);
  endtask

  task automatic test_backpressure();
    int nacc = 0;
    for (int i = 0; i < D; i++) drive(1, W'(32'h100 + i), 0, 0);
    checks++; if (out_valid !== 1'b1 || out_data !== m_data) begin errors++; $display("FAIL bp_first got v=%b %h want v=1 %h", out_valid, out_data, m_data); end
    for (int i = 0; i < D+1; i++) begin
      drive(1, W'(32'h200 + nacc), 0, 0);
      if (obs_rdy) nacc++;
      checks++; if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL bp_rdy cyc %0d got %b want %b", i, obs_rdy, exp_rdy); end
      checks++; if (out_valid !== 1'b1 || out_data !== m_data) begin errors++; $display("FAIL bp_hold cyc %0d got v=%b %h want v=1 %h", i, out_valid, out_data, m_data); end
    end
    checks++; if (nacc != D-1) begin errors++; $display("FAIL bp_accepted got %0d want %0d", nacc, D-1); end
    drive(1, W'(32'h200 + nacc), 1, 0);
    checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL bp_release_rdy got %b want 1", obs_rdy); end
    checks++; if (out_valid !== 1'b1 || out_data !== 128'h00000203_00000202_00000201_00000200) begin
      errors++; $display("FAIL bp_second got v=%b %h want v=1 00000203000002020000020100000200", out_valid, out_data); end
    drive(0, '0, 1, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    drive(1, 32'hDEAD0001, 1, 0);
    drive(1, 32'hDEAD0002, 1, 0);
    rst = 1; in_valid = 1; in_data = 32'hDEAD0003;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_rdy got %b want 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_cnt !== '0) begin
      errors++; $display("FAIL rmid_outputs got v=%b %h/%0d want all 0", out_valid, out_data, out_cnt); end
    model_reset();
    rst = 0;
    for (int i = 0; i < D; i++) drive(1, W'(32'hA0 + i), 1, 0);
    checks++; if (out_valid !== 1'b1 || out_cnt !== CW'(4) || out_data !== 128'h000000A3_000000A2_000000A1_000000A0) begin
      errors++; $display("FAIL rmid_clean got v=%b %h/%0d want v=1 000000a3000000a2000000a1000000a0/4", out_valid, out_data, out_cnt); end
    drive(0, '0, 1, 0);
  endtask

`ifdef INTRM_PACK_FLUSH_EN
  task automatic test_flush();
    drive(1, 32'hAA, 1, 0);
    drive(1, 32'hBB, 1, 0);
    drive(0, '0, 1, 1);
    checks++; if (out_valid !== 1'b1 || out_cnt !== CW'(2) || out_data !== 128'h000000BB_000000AA) begin
      errors++; $display("FAIL flush_partial got v=%b %h/%0d want v=1 bb000000aa/2", out_valid, out_data, out_cnt); end
    drive(0, '0, 1, 0);
    drive(0, '0, 1, 1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got %b want 0", out_valid); end
    drive(0, '0, 1, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty2 got %b want 0", out_valid); end
  endtask

  task automatic test_flush_stall();
    for (int i = 0; i < D; i++) drive(1, W'(32'hB0 + i), 0, 0);
    drive(1, 32'hC0, 0, 0);
    drive(1, 32'hC1, 0, 0);
    drive(0, '0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'hEE, 0, 0);
      checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL fstall_rdy cyc %0d got %b want 0", i, obs_rdy); end
      checks++; if (out_valid !== 1'b1 || out_data !== 128'h000000B3_000000B2_000000B1_000000B0) begin
        errors++; $display("FAIL fstall_full cyc %0d got v=%b %h", i, out_valid, out_data); end
    end
    drive(1, 32'hEE, 1, 0);
    checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL fstall_rel_rdy got %b want 0", obs_rdy); end
    checks++; if (out_valid !== 1'b1 || out_cnt !== CW'(2) || out_data !== 128'h000000C1_000000C0) begin
      errors++; $display("FAIL fstall_partial got v=%b %h/%0d want v=1 c1000000c0/2", out_valid, out_data, out_cnt); end
    drive(0, '0, 1, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fstall_drain got %b want 0", out_valid); end
  endtask
`endif

  task automatic test_random();
    bit fl;
    for (int i = 0; i < 400; i++) begin
      fl = 0;
`ifdef INTRM_PACK_FLUSH_EN
      fl = ($urandom_range(0, 7) == 0);
`endif
      drive($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 2) != 0, fl);
      checks++; if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL rand_rdy cyc %0d got %b want %b", i, obs_rdy, exp_rdy); end
      checks++; if (out_valid !== m_ov || (m_ov && (out_data !== m_data || out_cnt !== CW'(m_cnt)))) begin
        errors++; $display("FAIL rand_out cyc %0d got v=%b %h/%0d want v=%b %h/%0d", i, out_valid, out_data, out_cnt, m_ov, m_data, m_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stream();
    test_backpressure();
    test_reset_mid();
`ifdef INTRM_PACK_FLUSH_EN
    test_flush();
    test_flush_stall();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
